// File: rtl/uart_pkg.sv
// Shared UART definitions for the Basys3 serial path.
//
// Contents:
//   UART_DATA_W             - frame width in bits
//   UART_RX_FIFO_DEPTH_DEF  - default receive FIFO depth
//   UART_RX_FIFO_CNT_W      - occupancy width for the default depth (0..DEPTH)
//   uart_byte_t             - one received byte
//   uart_fifo_status_t      - packed status word for register maps
//   uart_fifo_status()      - helper that assembles a status word
package uart_pkg;

    localparam int unsigned UART_DATA_W            = 8;
    localparam int unsigned UART_RX_FIFO_DEPTH_DEF = 16;
    localparam int unsigned UART_RX_FIFO_CNT_W     = $clog2(UART_RX_FIFO_DEPTH_DEF) + 1;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

    typedef struct packed {
        logic [UART_RX_FIFO_CNT_W-1:0] count;
        logic                          full;
        logic                          empty;
        logic                          overflow;
    } uart_fifo_status_t;

    function automatic uart_fifo_status_t uart_fifo_status(
        input logic [UART_RX_FIFO_CNT_W-1:0] count,
        input logic                          full,
        input logic                          empty,
        input logic                          overflow
    );
        uart_fifo_status_t s;
        s.count    = count;
        s.full     = full;
        s.empty    = empty;
        s.overflow = overflow;
        return s;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte path between the UART receiver, the receive FIFO and its consumer.
//
// Signals:
//   frame_ready - byte-complete strobe from the receiver (level, edge-detected by the FIFO)
//   frame       - received byte, valid while frame_ready is high
//   rd_valid    - FIFO head entry available
//   rd_data     - FIFO head entry (first-word-fall-through)
//   rd_ready    - consumer accepts the head entry
//
// Modports:
//   master - receiver/consumer side (drives frame, frame_ready, rd_ready)
//   slave  - FIFO side
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = UART_DATA_W
);

    logic             frame_ready;
    logic [WIDTH-1:0] frame;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             rd_ready;

    modport master (
        output frame_ready,
        output frame,
        output rd_ready,
        input  rd_valid,
        input  rd_data
    );

    modport slave (
        input  frame_ready,
        input  frame,
        input  rd_ready,
        output rd_valid,
        output rd_data
    );

endinterface

// File: rtl/uart_fifo_ram.sv
// Simple dual-port storage array for the UART receive FIFO.
// One synchronous write port, one asynchronous read port. Contents are not reset.
//
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational from raddr)
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = UART_RX_FIFO_DEPTH_DEF,
    parameter int unsigned WIDTH  = UART_DATA_W,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive byte buffer: first-word-fall-through FIFO between the UART
// receiver and the byte consumer.
//
// One byte is captured per rising edge of frame_ready. The head entry is
// presented over a valid/ready handshake with zero added latency. Bytes that
// arrive while the FIFO is full (and not being drained in the same cycle) are
// dropped and latch the sticky overflow flag.
//
// Parameters:
//   DEPTH  - number of entries, power of 2, at least 2
//   WIDTH  - data width in bits
//   ADDR_W - pointer width, derived from DEPTH
//
// Ports:
//   clk      - system clock
//   RST_N    - asynchronous active-low reset
//   bus      - byte path (uart_rx_fifo_if.slave): frame/frame_ready in, rd_* out
//   count    - occupancy, 0..DEPTH
//   full     - count == DEPTH
//   empty    - count == 0
//   overflow - sticky: at least one byte dropped
//   ovf_clr  - single-cycle clear of overflow (a same-cycle drop wins)
//   hwm      - high-water mark of count (only with UART_RX_FIFO_HWM_EN)
//
// Build option:
//   UART_RX_FIFO_HWM_EN - adds the hwm output and its tracking register.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = UART_RX_FIFO_DEPTH_DEF,
    parameter int unsigned WIDTH  = UART_DATA_W,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              RST_N,
    uart_rx_fifo_if.slave     bus,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              ovf_clr
`ifdef UART_RX_FIFO_HWM_EN
    ,
    output logic [ADDR_W:0]   hwm
`endif
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic              fr_q;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_next;
    logic              overflow_q;

    logic              push_req;
    logic              pop;
    logic              push;
    logic              drop;
    logic              is_full;
    logic              is_empty;

    // Flags come from the registered count, never from pointer comparison.
    assign is_full  = (count_q == FULL_CNT);
    assign is_empty = (count_q == '0);

    // fr_q resets to 1 so a strobe already high at reset release is not a new byte.
    assign push_req = bus.frame_ready & ~fr_q;

    // rd_valid is !empty, so a pop request against an empty FIFO is masked here.
    assign pop  = ~is_empty & bus.rd_ready;

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push = push_req & (~is_full | pop);
    assign drop = push_req & is_full & ~pop;

    always_comb begin
        count_next = count_q;
        if (push && !pop) begin
            count_next = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_next = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            fr_q       <= 1'b1;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            fr_q    <= bus.frame_ready;
            count_q <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // Set has priority over clear.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    uart_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.frame),
        .raddr (rd_ptr),
        .rdata (bus.rd_data)
    );

    assign bus.rd_valid = ~is_empty;
    assign count        = count_q;
    assign full         = is_full;
    assign empty        = is_empty;
    assign overflow     = overflow_q;

`ifdef UART_RX_FIFO_HWM_EN
    logic [ADDR_W:0] hwm_q;
    logic [ADDR_W:0] hwm_next;

    // A clear restarts tracking from the occupancy this cycle leaves behind.
    always_comb begin
        hwm_next = hwm_q;
        if (ovf_clr) begin
            hwm_next = count_next;
        end else if (count_next > hwm_q) begin
            hwm_next = count_next;
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_next;
        end
    end

    assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (DEPTH=16, WIDTH=8).
module tb_uart_rx_fifo;

    logic       clk;
    logic       RST_N;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       ovf_clr;
`ifdef UART_RX_FIFO_HWM_EN
    logic [4:0] hwm;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_fifo_if #(.WIDTH(8)) bus ();

    uart_rx_fifo #(
        .DEPTH (16),
        .WIDTH (8)
    ) dut (
        .clk      (clk),
        .RST_N    (RST_N),
        .bus      (bus),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
`ifdef UART_RX_FIFO_HWM_EN
        ,
        .hwm      (hwm)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       fr;
        logic [7:0] d;
        logic       rdy;
        logic [4:0] cnt;
        logic [7:0] dat;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive on the falling edge, return 1 time unit after the rising edge.
    task automatic step(input logic fr, input logic [7:0] d, input logic rdy, input logic clr);
        @(negedge clk);
        bus.frame_ready = fr;
        bus.frame       = d;
        bus.rd_ready    = rdy;
        ovf_clr         = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic chk_status(input string name, input logic [4:0] cnt, input logic ovf);
        chk({name, ".count"}, 32'(count), 32'(cnt));
        chk({name, ".full"}, 32'(full), 32'(cnt == 5'd16));
        chk({name, ".empty"}, 32'(empty), 32'(cnt == 5'd0));
        chk({name, ".rd_valid"}, 32'(bus.rd_valid), 32'(cnt != 5'd0));
        chk({name, ".overflow"}, 32'(overflow), 32'(ovf));
    endtask

    initial begin
        // Held strobe across reset release, single push from a 3-cycle strobe,
        // pop while empty, empty push+pop, non-empty push+pop.
        vecs[0]  = '{1'b1, 8'h00, 1'b0, 5'd0, 8'h00};
        vecs[1]  = '{1'b1, 8'h00, 1'b0, 5'd0, 8'h00};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 5'd0, 8'h00};
        vecs[3]  = '{1'b1, 8'hA5, 1'b0, 5'd1, 8'hA5};
        vecs[4]  = '{1'b1, 8'hA5, 1'b0, 5'd1, 8'hA5};
        vecs[5]  = '{1'b1, 8'h99, 1'b0, 5'd1, 8'hA5};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 5'd0, 8'h00};
        vecs[7]  = '{1'b1, 8'h3C, 1'b1, 5'd1, 8'h3C};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 5'd0, 8'h00};
        vecs[9]  = '{1'b1, 8'h11, 1'b0, 5'd1, 8'h11};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 5'd1, 8'h11};
        vecs[11] = '{1'b1, 8'h22, 1'b0, 5'd2, 8'h11};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 5'd1, 8'h22};
        vecs[13] = '{1'b1, 8'h33, 1'b1, 5'd1, 8'h33};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 5'd0, 8'h00};

        RST_N           = 1'b0;
        bus.frame_ready = 1'b1;
        bus.frame       = 8'h00;
        bus.rd_ready    = 1'b0;
        ovf_clr         = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        RST_N = 1'b1;
        #1;
        chk_status("reset", 5'd0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].fr, vecs[i].d, vecs[i].rdy, 1'b0);
            chk_status($sformatf("vec%0d", i), vecs[i].cnt, 1'b0);
            if (vecs[i].cnt != 5'd0) begin
                chk($sformatf("vec%0d.rd_data", i), 32'(bus.rd_data), 32'(vecs[i].dat));
            end
        end

        // Fill, overflow on the 17th byte, then drain in order.
        for (int i = 0; i < 16; i++) push(8'(i));
        chk_status("fill16", 5'd16, 1'b0);
        push(8'hFF);
        chk_status("drop_ff", 5'd16, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d.rd_data", i), 32'(bus.rd_data), 32'(i));
            chk($sformatf("drain%0d.rd_valid", i), 32'(bus.rd_valid), 32'd1);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk_status("drained", 5'd0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk_status("ovf_clr1", 5'd0, 1'b0);

        // Full FIFO, push in the same cycle as a pop: accepted, no overflow.
        for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        chk_status("full_pushpop", 5'd16, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain2_%0d.rd_data", i), 32'(bus.rd_data),
                (i < 15) ? 32'(8'h41 + i) : 32'h5A);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk_status("drained2", 5'd0, 1'b0);

        // Drop coinciding with ovf_clr: set wins; a later lone clear works.
        for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
        push(8'hFF);
        chk_status("drop2", 5'd16, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        chk_status("drop_and_clr", 5'd16, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk_status("lone_clr", 5'd16, 1'b0);
        chk("head_after_drops", 32'(bus.rd_data), 32'h80);
`ifdef UART_RX_FIFO_HWM_EN
        chk("hwm_full", 32'(hwm), 32'd16);
`endif

        // Asynchronous reset mid-operation clears state without a clock edge.
        @(negedge clk);
        #2;
        RST_N = 1'b0;
        #1;
        chk_status("async_rst", 5'd0, 1'b0);
`ifdef UART_RX_FIFO_HWM_EN
        chk("hwm_rst", 32'(hwm), 32'd0);
`endif
        @(negedge clk);
        RST_N = 1'b1;
        push(8'h77);
        chk_status("after_rst", 5'd1, 1'b0);
        chk("after_rst.rd_data", 32'(bus.rd_data), 32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the UART receiver on the Basys3 serial path. It captures each completed frame (frame/frame_ready) into a first-word-fall-through FIFO and presents bytes to the consumer (command parser, display logic) over a valid/ready handshake. It absorbs bursts, reports fill level, and flags bytes lost to overflow.

Parameters:
DEPTH, 16, number of byte entries; must be a power of 2, at least 2
WIDTH, 8, data width in bits; matches the UART frame width
ADDR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  input  1  system clock
RST_N  input  1  reset; asynchronous, active-low
frame_ready  input  1  byte-complete strobe from the UART receiver; may be held high for more than one cycle
frame  input  WIDTH  received byte; valid while frame_ready is high
rd_valid  output  1  head entry available (equals not empty)
rd_data  output  WIDTH  head entry; FWFT; stable while rd_valid is high and rd_ready is low
rd_ready  input  1  consumer accepts the head entry
count  output  ADDR_W+1  current occupancy, range 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky flag: at least one byte dropped
ovf_clr  input  1  single-cycle clear of overflow

Behaviour:
- Reset (async assert, sync release): rd_ptr=0, wr_ptr=0, count=0, empty=1, full=0, rd_valid=0, overflow=0, edge register fr_q=1. Storage contents are not reset; rd_data is don't-care while rd_valid=0.
- fr_q resets to 1, so a frame_ready held high across reset release does not push.
- Push detect: push_req = frame_ready & ~fr_q. fr_q <= frame_ready every cycle. Exactly one push per rising edge of frame_ready. frame is sampled in the same cycle as the edge.
- Pop: pop = rd_valid & rd_ready. A pop while empty is ignored; pointers and count do not change.
- Push accepted if (!full) or pop occurs in the same cycle. Both cases write mem[wr_ptr] and increment wr_ptr modulo DEPTH.
- Push while full with no pop: the byte is dropped, pointers and count are unchanged, overflow <= 1.
- Simultaneous push and pop:
  - Not empty: both happen; count is unchanged.
  - Empty: the pop is ignored (rd_valid=0); the push is accepted.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither. It never exceeds DEPTH and never drops below 0.
- Pointers are ADDR_W wide and wrap naturally. full/empty are derived from count, not from pointer comparison.
- Latency: a push edge sampled at posedge k makes rd_valid=1 and rd_data=frame right after posedge k. Zero bubble on a back-to-back consumer.
- Pop at posedge k: rd_data shows the next entry right after k, or rd_valid=0 if the FIFO became empty.
- overflow is cleared by ovf_clr. If ovf_clr and a new drop occur in the same cycle, set wins (overflow stays 1).
- Reset asserted mid-operation clears state immediately. Any bytes held are discarded.
- All outputs are registered or derived directly from registers. There is no combinational path from frame_ready to rd_valid.

Optional Feature:
Macro UART_RX_FIFO_HWM_EN.
- Defined: adds output hwm [ADDR_W:0], a high-water mark.
  - Reset value is 0.
  - hwm <= max(hwm, count_next) every cycle.
  - Cleared to 0 by ovf_clr, unless the same-cycle count_next exceeds 0, in which case hwm takes count_next.
- Not defined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package uart_pkg:
  - UART_DATA_W = 8
  - UART_RX_FIFO_DEPTH_DEF = 16
  - typedef uart_byte_t (logic [UART_DATA_W-1:0])
  - typedef struct uart_fifo_status_t {count, full, empty, overflow}, for status register maps
- One natural sub-module: uart_fifo_ram. Simple dual-port array with one synchronous write port and one asynchronous read port, holding DEPTH x WIDTH. Pointer, count and flag control stays in uart_rx_fifo.

Test Plan:
- Reset release with frame_ready held high -> no push; count=0, empty=1, rd_valid=0.
- frame_ready high for 3 cycles, frame=0xA5, rd_ready=0 -> exactly one entry; count=1, rd_data=0xA5 the cycle after the edge.
- 16 pushes (0x00..0x0F) with rd_ready=0, then a 17th push of 0xFF:
  - full=1, overflow=1, count=16, 0xFF lost.
  - Draining with rd_ready=1 yields 0x00..0x0F in order, one per cycle; empty=1 afterward.
- FIFO full, push of 0x5A in the same cycle as a pop -> overflow stays 0, count stays 16, 0x5A is the last byte read out.
- FIFO empty, push of 0x3C with rd_ready=1 in the same cycle -> the pop is ignored; count=1; 0x3C is popped on the next cycle.
- overflow set, ovf_clr pulsed in the same cycle as another dropped push -> overflow remains 1. A later lone ovf_clr gives overflow=0.
